// File: rtl/axi_mem_arbiter_if.sv
// Signal bundle joining the core's I and D memory ports, the arbiter and the axi_controller.
// master: arbiter side (drives m_* and the ready/load returns); slave: core and controller side.
interface axi_mem_arbiter_if;
    logic        i_read;
    logic [31:0] i_addr;
    logic        i_done;
    logic        i_ready;
    logic [31:0] i_load;

    logic        d_read;
    logic [1:0]  d_write;
    logic [31:0] d_addr;
    logic [31:0] d_store;
    logic        d_done;
    logic        d_ready;
    logic [31:0] d_load;

    logic        m_read;
    logic [1:0]  m_write;
    logic [31:0] m_addr;
    logic [31:0] m_store;
    logic        m_done;
    logic        m_ready;
    logic [31:0] m_load;

    modport master (
        input  i_read, i_addr, i_done,
        input  d_read, d_write, d_addr, d_store, d_done,
        input  m_ready, m_load,
        output i_ready, i_load, d_ready, d_load,
        output m_read, m_write, m_addr, m_store, m_done
    );

    modport slave (
        output i_read, i_addr, i_done,
        output d_read, d_write, d_addr, d_store, d_done,
        output m_ready, m_load,
        input  i_ready, i_load, d_ready, d_load,
        input  m_read, m_write, m_addr, m_store, m_done
    );
endinterface

// File: rtl/axi_mem_arbiter.sv
// Round-robin arbiter sharing one axi_controller between instruction fetch (I) and load/store (D).
// Optional watchdog enabled by defining ARB_TIMEOUT_EN; otherwise timeout_err is tied low.
module axi_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              nrst,
    axi_mem_arbiter_if.master bus,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IBUS = 2'd1,
        ARB_DBUS = 2'd2
    } arb_state_t;

    arb_state_t  state;
    arb_state_t  next_state;
    logic        last_grant_d;
    logic        abandoned;
    logic        lat_read;
    logic [1:0]  lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_store;
    logic        i_pending;
    logic        d_pending;
    logic        owner_pending;
    logic        owner_done;
    logic        complete;

    assign i_pending = bus.i_read;
    assign d_pending = bus.d_read | (bus.d_write != 2'b00);

    always_comb begin
        next_state    = state;
        owner_pending = 1'b0;
        owner_done    = 1'b0;
        bus.i_ready   = 1'b0;
        bus.d_ready   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (i_pending && (!d_pending || last_grant_d)) begin
                    next_state = ARB_IBUS;
                end else if (d_pending) begin
                    next_state = ARB_DBUS;
                end
            end
            ARB_IBUS: begin
                bus.i_ready   = bus.m_ready;
                owner_pending = i_pending;
                owner_done    = bus.i_done;
            end
            ARB_DBUS: begin
                bus.d_ready   = bus.m_ready;
                owner_pending = d_pending;
                owner_done    = bus.d_done;
            end
            default: next_state = ARB_IDLE;
        endcase
        // A requester that walked away still gets its transaction closed so AXI is never aborted
        bus.m_done = bus.m_ready && (state != ARB_IDLE)
                     && (owner_done || abandoned || !owner_pending);
        complete   = bus.m_done;
        if (complete) begin
            next_state = ARB_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state        <= ARB_IDLE;
            last_grant_d <= 1'b0;
            abandoned    <= 1'b0;
            lat_read     <= 1'b0;
            lat_write    <= 2'b00;
            lat_addr     <= 32'h0;
            lat_store    <= 32'h0;
        end else begin
            state     <= next_state;
            abandoned <= (state != ARB_IDLE) && !complete && (abandoned || !owner_pending);
            if (state == ARB_IDLE && next_state == ARB_IBUS) begin
                lat_read  <= 1'b1;
                lat_write <= 2'b00;
                lat_addr  <= bus.i_addr;
                lat_store <= 32'h0;
            end else if (state == ARB_IDLE && next_state == ARB_DBUS) begin
                lat_read  <= bus.d_read && (bus.d_write == 2'b00);
                lat_write <= bus.d_write;
                lat_addr  <= bus.d_addr;
                lat_store <= bus.d_store;
            end else if (complete) begin
                lat_read     <= 1'b0;
                lat_write    <= 2'b00;
                lat_addr     <= 32'h0;
                lat_store    <= 32'h0;
                last_grant_d <= (state == ARB_DBUS);
            end
        end
    end

    // The controller only ever sees the captured request, cleared outside a grant
    assign bus.m_read  = lat_read;
    assign bus.m_write = lat_write;
    assign bus.m_addr  = lat_addr;
    assign bus.m_store = lat_store;
    assign bus.i_load  = bus.m_load;
    assign bus.d_load  = bus.m_load;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wd_count;
    logic             wd_err;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wd_count <= '0;
            wd_err   <= 1'b0;
        end else if (state == ARB_IDLE) begin
            wd_count <= '0;
        end else if (!bus.m_ready && wd_count != LIMIT) begin
            wd_count <= wd_count + CNT_W'(1);
            if (wd_count == LIMIT - CNT_W'(1)) begin
                wd_err <= 1'b1;
            end
        end
    end

    assign timeout_err = wd_err;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Scoreboard bench for axi_mem_arbiter: rounds of I/D requests, predicted grant order and memory
// contents in queues, and a controller model that pops and checks each granted transaction.
module tb_axi_mem_arbiter;

    localparam int TB_TIMEOUT = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        bit          who;
        logic        rd;
        logic [1:0]  wr;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] load;
    } exp_t;

    logic clk = 1'b0;
    logic nrst;
    logic timeout_err;

    axi_mem_arbiter_if bus();

    axi_mem_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .bus        (bus),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ctl_mem [logic [31:0]];
    bit          ref_last_d  = 1'b0;
    int          checks      = 0;
    int          errors      = 0;
    int          pushed      = 0;
    int          completed   = 0;
    bit          i_hold      = 1'b0;
    bit          d_hold      = 1'b0;
    bit          mon_busy    = 1'b0;
    bit          mon_who     = 1'b0;
    int          forced_lat  = 0;
    bit          exp_timeout = 1'b0;

    // Requesters acknowledge in the same cycle their ready arrives, while still interested
    assign bus.i_done = i_hold & bus.i_ready;
    assign bus.d_done = d_hold & bus.d_ready;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
        end
    endtask

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h20 + 32'($urandom_range(0, 7)) * 32'd4;
    endfunction

    function automatic void push_exp(input bit who, input logic rd, input logic [1:0] wr,
                                     input logic [31:0] a, input logic [31:0] s);
        exp_t e;
        e.who   = who;
        e.wr    = who ? wr : 2'b00;
        e.rd    = who ? (rd && wr == 2'b00) : 1'b1;
        e.addr  = a;
        e.store = who ? s : 32'h0;
        e.load  = ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
        if (e.wr != 2'b00) ref_mem[a] = s;
        exp_q.push_back(e);
        pushed++;
        ref_last_d = who;
    endfunction

    // Controller model: serves one granted transaction and checks everything the DUT presents
    task automatic run_txn(input exp_t e);
        int k;
        int first_ready;
        bit rdy;
        mon_busy    = 1'b1;
        mon_who     = e.who;
        rdy         = 1'b0;
        k           = 1;
        first_ready = ((forced_lat > 0) ? forced_lat : $urandom_range(0, 4)) + 2;
        while (1) begin
            check_output("m_read", bus.m_read, e.rd);
            check_output("m_write", bus.m_write, e.wr);
            check_output("m_addr", bus.m_addr, e.addr);
            check_output("m_store", bus.m_store, e.store);
            check_output("i_ready", bus.i_ready, rdy && !e.who);
            check_output("d_ready", bus.d_ready, rdy && e.who);
            check_output("m_done", bus.m_done, rdy);
            if (rdy && e.rd)
                check_output(e.who ? "d_load" : "i_load", e.who ? bus.d_load : bus.i_load, e.load);
            if (TO_EN && k > TB_TIMEOUT && first_ready > TB_TIMEOUT) exp_timeout = 1'b1;
            check_output("timeout_err", timeout_err, exp_timeout);
            if (rdy) break;
            @(posedge clk); #1;
            k++;
            if (k >= first_ready) begin
                rdy         = 1'b1;
                bus.m_ready = 1'b1;
                bus.m_load  = ctl_mem.exists(bus.m_addr) ? ctl_mem[bus.m_addr] : mem_default(bus.m_addr);
            end
            @(negedge clk);
        end
        if (bus.m_write != 2'b00) ctl_mem[bus.m_addr] = bus.m_store;
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        bus.m_load  = $urandom;
        @(negedge clk);
        check_output("idle_m_read", bus.m_read, 1'b0);
        check_output("idle_m_write", bus.m_write, 2'b00);
        check_output("idle_ready", bus.i_ready | bus.d_ready, 1'b0);
        mon_busy = 1'b0;
        completed++;
    endtask

    initial begin : monitor
        bus.m_ready = 1'b0;
        bus.m_load  = 32'h0;
        forever begin
            @(negedge clk);
            if (nrst === 1'b1 && (bus.m_read === 1'b1 || bus.m_write != 2'b00)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_txn: got m_addr 0x%08h, expected no transaction", bus.m_addr);
                end else begin
                    run_txn(exp_q.pop_front());
                end
            end
        end
    end

    // One round: raise the chosen requests together, hold them until ready, meddle mid-grant
    task automatic apply_stimulus(input bit use_i, input bit use_d, input logic [31:0] ia,
                                  input logic d_rd, input logic [1:0] d_wr, input logic [31:0] da,
                                  input logic [31:0] ds, input bit d_abandon, input int lat);
        bit i_busy, d_busy, i_seen, d_seen;
        int age, iter, target;
        @(posedge clk); #1;
        forced_lat = lat;
        if (use_i && use_d) begin
            if (ref_last_d) begin
                push_exp(1'b0, 1'b1, 2'b00, ia, 32'h0);
                push_exp(1'b1, d_rd, d_wr, da, ds);
            end else begin
                push_exp(1'b1, d_rd, d_wr, da, ds);
                push_exp(1'b0, 1'b1, 2'b00, ia, 32'h0);
            end
        end else if (use_i) begin
            push_exp(1'b0, 1'b1, 2'b00, ia, 32'h0);
        end else if (use_d) begin
            push_exp(1'b1, d_rd, d_wr, da, ds);
        end
        target      = pushed;
        bus.i_read  = use_i;
        bus.i_addr  = ia;
        i_hold      = use_i;
        i_busy      = use_i;
        bus.d_read  = use_d & d_rd;
        bus.d_write = use_d ? d_wr : 2'b00;
        bus.d_addr  = da;
        bus.d_store = ds;
        d_hold      = use_d;
        d_busy      = use_d;
        age         = 0;
        iter        = 0;
        while ((i_busy || d_busy) && iter < 300) begin
            @(negedge clk);
            iter++;
            if (iter == 1) check_output("arb_latency_idle", bus.m_read | (bus.m_write != 2'b00), 1'b0);
            if (iter == 2) check_output("arb_latency_grant", bus.m_read | (bus.m_write != 2'b00), 1'b1);
            i_seen = i_busy && bus.i_ready;
            d_seen = d_busy && bus.d_ready;
            @(posedge clk); #1;
            if (i_seen) begin
                i_busy = 1'b0; i_hold = 1'b0; bus.i_read = 1'b0; bus.i_addr = $urandom;
            end
            if (d_seen) begin
                d_busy = 1'b0; d_hold = 1'b0; bus.d_read = 1'b0; bus.d_write = 2'b00;
            end
            if (i_busy && mon_busy && !mon_who) bus.i_addr = $urandom;
            if (d_busy && mon_busy && mon_who) begin
                bus.d_addr  = $urandom;
                bus.d_store = $urandom;
                age++;
                if (d_abandon && age == 2) begin
                    d_busy = 1'b0; d_hold = 1'b0; bus.d_read = 1'b0; bus.d_write = 2'b00;
                end
            end
        end
        check_output("requester_served", {i_busy, d_busy}, 2'b00);
        iter = 0;
        while (completed < target && iter < 300) begin
            @(negedge clk);
            iter++;
        end
        check_output("round_complete", completed, target);
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    initial begin : stimulus
        int          kind;
        logic        d_rd;
        logic [1:0]  d_wr;
        nrst        = 1'b0;
        bus.i_read  = 1'b0;
        bus.i_addr  = 32'h0;
        bus.d_read  = 1'b0;
        bus.d_write = 2'b00;
        bus.d_addr  = 32'h0;
        bus.d_store = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_m_read", bus.m_read, 1'b0);
        check_output("rst_m_write", bus.m_write, 2'b00);
        check_output("rst_m_addr", bus.m_addr, 32'h0);
        check_output("rst_m_store", bus.m_store, 32'h0);
        check_output("rst_m_done", bus.m_done, 1'b0);
        check_output("rst_ready", {bus.i_ready, bus.d_ready}, 2'b00);
        check_output("rst_timeout_err", timeout_err, 1'b0);
        @(posedge clk); #1;
        nrst = 1'b1;

        $display("[TB] directed rounds");
        apply_stimulus(1'b1, 1'b1, 32'h100, 1'b1, 2'b00, 32'h20, 32'h0, 1'b0, 0);
        apply_stimulus(1'b0, 1'b1, 32'h0, 1'b0, 2'b11, 32'h20, 32'h0, 1'b0, 0);
        apply_stimulus(1'b0, 1'b1, 32'h0, 1'b0, 2'b11, 32'h20, 32'hABCD1234, 1'b0, 3);
        apply_stimulus(1'b1, 1'b0, 32'h20, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 0);
        for (int r = 0; r < 3; r++)
            apply_stimulus(1'b1, 1'b1, rand_addr(), 1'b1, 2'b00, rand_addr(), 32'h0, 1'b0, 0);
        apply_stimulus(1'b0, 1'b1, 32'h0, 1'b1, 2'b00, 32'h28, 32'h0, 1'b1, 5);
        apply_stimulus(1'b0, 1'b1, 32'h0, 1'b1, 2'b00, 32'h2C, 32'h0, 1'b0, 20);

        $display("[TB] random rounds");
        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 2);
            d_wr = 2'($urandom_range(0, 3));
            d_rd = 1'($urandom_range(0, 1));
            if (!d_rd && d_wr == 2'b00) d_rd = 1'b1;
            apply_stimulus(kind != 1, kind != 0, rand_addr(), d_rd, d_wr, rand_addr(), $urandom, 1'b0, 0);
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        check_output("final_timeout_err", timeout_err, exp_timeout);
        check_output("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        errors++;
        $display("[TB] FAIL watchdog: got no end of test, expected finish within 1 ms");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/axi_mem_arbiter.md
# axi_mem_arbiter

Two-port arbiter sharing the single AXI memory controller (DDR3 via MIG) between an instruction-fetch requester (I) and a load/store requester (D). It grants one requester at a time with round-robin fairness, and latches the granted request so the controller sees stable inputs for the whole transaction. It routes the completion handshake back to the granted requester only. It sits between the core's memory ports and the `axi_controller` memory-side interface.

## Interface
- TIMEOUT_CYCLES, 1024: watchdog limit in clk cycles (used only with ARB_TIMEOUT_EN).
- clk  in  1  clock; all logic is posedge.
- nrst  in  1  reset, synchronous, active-low.
- i_read  in  1  I read request; held until i_ready.
- i_addr  in  32  I address.
- i_done  in  1  I acknowledge; asserted together with i_ready.
- i_ready  out  1  I transaction complete.
- i_load  out  32  read data, valid while i_ready.
- d_read  in  1  D read request.
- d_write  in  2  D write request/size code; nonzero means write; passed through unchanged.
- d_addr  in  32  D address.
- d_store  in  32  D write data.
- d_done  in  1  D acknowledge.
- d_ready  out  1  D transaction complete.
- d_load  out  32  read data.
- m_read  out  1  to controller read.
- m_write  out  2  to controller write code.
- m_addr  out  32  to controller address.
- m_store  out  32  to controller write data.
- m_done  out  1  to controller acknowledge.
- m_ready  in  1  from controller completion.
- m_load  in  32  from controller read data.
- timeout_err  out  1  sticky watchdog flag (ARB_TIMEOUT_EN only; tied 0 otherwise).

## Operation
- States: ARB_IDLE, ARB_IBUS, ARB_DBUS.
- A requester is pending when I: i_read; D: d_read or d_write != 0.
- In ARB_IDLE:
  - Only one requester pending: grant it.
  - Both pending: grant the one not granted last (last_grant register).
  - After reset, last_grant = I, so D wins the first tie.
  - On grant, the request (read, write, addr, store) is captured into registers and the state moves to ARB_IBUS or ARB_DBUS.
- In ARB_xBUS:
  - m_read, m_write, m_addr and m_store are driven from the latched registers only.
  - Requester input changes are ignored until the transaction completes.
- Completion:
  - m_ready is routed to the granted requester's x_ready only; the other ready stays 0.
  - m_done = granted x_done & m_ready.
  - When m_ready & m_done: return to ARB_IDLE and update last_grant.
- Abandoned request: if the granted requester drops its request before m_ready, the arbiter keeps driving the latched request. On m_ready it self-asserts m_done and returns to ARB_IDLE. The AXI transaction is never aborted.
- D read and write both nonzero: treated as a write (m_read = 0).
- m_load drives both i_load and d_load; data is only meaningful while that port's x_ready is high.

## Timing
- Reset values:
  - State ARB_IDLE, last_grant = I, latched registers 0.
  - All m_* outputs 0; i_ready, d_ready and timeout_err 0.
- Arbitration latency is 1 cycle: a request seen in ARB_IDLE at cycle N reaches m_* at cycle N+1.
- Ready path is combinational: x_ready follows m_ready in the same cycle.
- After completion there is one mandatory ARB_IDLE cycle, so back-to-back grants are spaced by at least 1 idle cycle.
- A request pending during another's grant waits and is granted in the ARB_IDLE cycle after completion.
- Reset mid-grant returns to ARB_IDLE immediately; m_* deassert the next cycle.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter runs while in ARB_IBUS or ARB_DBUS and clears in ARB_IDLE.
  - Reaching TIMEOUT_CYCLES without m_ready sets timeout_err, which stays set until reset.
  - Arbitration behaviour is unchanged.
- ARB_TIMEOUT_EN undefined: no counter; timeout_err tied to 0.

## Test plan
- D-only write:
  - Stimulus: d_write=2'b11, d_addr=0x20, d_store=0.
  - Response: m_write=2'b11, m_addr=0x20 one cycle later; d_ready pulses with m_ready; i_ready stays 0.
- Simultaneous requests after reset:
  - Stimulus: i_read addr 0x100 and d_read addr 0x20 in the same cycle.
  - Response: D granted first; after completion and 1 idle cycle, I granted with m_addr=0x100.
- Alternation:
  - Stimulus: both requesters continuously requesting for 6 transactions.
  - Response: grant order D,I,D,I,D,I.
- Data return and latching:
  - Stimulus: D write 0xABCD1234 to 0x20, then I read 0x20; change d_addr mid-grant.
  - Response: m_addr stays 0x20; i_load=0xABCD1234 with i_ready.
- Abandoned request:
  - Stimulus: d_read deasserted 2 cycles after grant.
  - Response: m_read held until m_ready; m_done asserted by the arbiter; return to ARB_IDLE.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: m_ready held low.
  - Response: timeout_err=1 after 16 grant cycles and remains 1 after m_ready finally arrives.
